// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_pkg
// Brief   : Shared constants and FSM encoding for the I2C transaction scheduler.
// Rev     : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int c_fclk    = 50_000_000;
    localparam int c_fvel    = 1_250_000;
    localparam int c_n4vel   = c_fclk / (4 * c_fvel);
    localparam int c_gap_cyc = 4 * c_n4vel;

    localparam int c_r_w_bit = 0;

    localparam int                   c_state_w      = 3;
    localparam logic [c_state_w-1:0] c_st_idle      = 3'd0;
    localparam logic [c_state_w-1:0] c_st_launch    = 3'd1;
    localparam logic [c_state_w-1:0] c_st_wait_busy = 3'd2;
    localparam logic [c_state_w-1:0] c_st_wait_done = 3'd3;
    localparam logic [c_state_w-1:0] c_st_eval      = 3'd4;
    localparam logic [c_state_w-1:0] c_st_resp      = 3'd5;
    localparam logic [c_state_w-1:0] c_st_gap       = 3'd6;

endpackage
`default_nettype wire

// File: rtl/i2c_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : i2c_rr_arbiter
// Brief   : Round-robin one-hot pick; pointer advances to the pick on i_upd.
// Rev     : 1.0 - initial release
// ============================================================================
module i2c_rr_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic                     i_upd,
    output logic                     o_any,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic [N_REQ-1:0]         o_pick
);

    localparam int c_ix_w = $clog2(N_REQ);

    logic [c_ix_w-1:0] r_last;
    int                w_cand;

    // Reset points at the last requester so the search starts at requester 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= c_ix_w'(N_REQ - 1);
        end else if (i_upd) begin
            r_last <= o_idx;
        end
    end

    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        o_pick = '0;
        w_cand = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = (int'(r_last) + k) % N_REQ;
            if (!o_any && i_req[w_cand[c_ix_w-1:0]]) begin
                o_any = 1'b1;
                o_idx = w_cand[c_ix_w-1:0];
            end
        end
        o_pick[o_idx] = o_any;
    end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_sched.sv
`default_nettype none
// ============================================================================
// Module  : i2c_txn_sched
// Brief   : Round-robin scheduler sharing one I2C master among requesters.
// Rev     : 1.0 - initial release
// ============================================================================
module i2c_txn_sched
    import i2c_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int MAX_RETRY = 2,
    parameter int GAP_CYC   = c_gap_cyc,
    parameter int START_TO  = 8,
    parameter int TIMEOUT   = 2048
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_adr_com,
    input  logic [8*N_REQ-1:0] req_adr_reg,
    input  logic [8*N_REQ-1:0] req_dat_reg,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               rsp_err,
    output logic               rsp_timeout,
    output logic [7:0]         rsp_dat,
    output logic               busy,
    output logic               m_st,
    output logic [7:0]         m_adr_com,
    output logic [7:0]         m_adr_reg,
    output logic [7:0]         m_dat_reg,
    input  logic               m_en_tx,
    input  logic               m_err_ac,
    input  logic [7:0]         m_rx_dat
);

    localparam int c_ix_w = $clog2(N_REQ);
    localparam int c_wd_w = $clog2(TIMEOUT + 1);
    localparam int c_rt_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int c_gp_w = $clog2(GAP_CYC + 1);

    localparam logic [c_wd_w-1:0] c_start_lim = c_wd_w'(START_TO - 1);
    localparam logic [c_wd_w-1:0] c_tmo_lim   = c_wd_w'(TIMEOUT - 1);
    localparam logic [c_gp_w-1:0] c_gap_lim   = c_gp_w'(GAP_CYC - 1);
    localparam logic [c_rt_w-1:0] c_max_retry = c_rt_w'(MAX_RETRY);

    logic [c_state_w-1:0] r_state, w_state_nxt;
    logic                 w_sel;
    logic                 w_any;
    logic [c_ix_w-1:0]    w_idx;
    logic [N_REQ-1:0]     w_pick;

    logic [N_REQ-1:0]  r_gnt, r_done, w_done;
    logic              r_rsp_err, r_rsp_timeout, r_busy, r_m_st;
    logic              w_rsp_err, w_rsp_timeout, w_busy, w_m_st;
    logic [7:0]        r_rsp_dat, w_rsp_dat;
    logic [7:0]        r_adr_com, r_adr_reg, r_dat_reg, r_rx_cap;
    logic              r_err_cap;
    logic [c_rt_w-1:0] r_retry;
    logic [c_wd_w-1:0] r_wdog;
    logic [c_gp_w-1:0] r_gap;

    i2c_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (req),
        .i_upd  (w_sel),
        .o_any  (w_any),
        .o_idx  (w_idx),
        .o_pick (w_pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = 1'b0;
        case (r_state)
            c_st_idle: begin
                // Holding off while en_tx is high covers a reset taken mid-transfer.
                if (w_any && !m_en_tx) begin
                    w_sel       = 1'b1;
                    w_state_nxt = c_st_launch;
                end
            end
            c_st_launch:    w_state_nxt = c_st_wait_busy;
            c_st_wait_busy: begin
                if (m_en_tx)                    w_state_nxt = c_st_wait_done;
                else if (r_wdog == c_start_lim) w_state_nxt = c_st_resp;
            end
            c_st_wait_done: begin
                if (!m_en_tx)                 w_state_nxt = c_st_eval;
                else if (r_wdog == c_tmo_lim) w_state_nxt = c_st_resp;
            end
            c_st_eval: begin
                if (r_err_cap && (r_retry < c_max_retry)) w_state_nxt = c_st_gap;
                else                                     w_state_nxt = c_st_resp;
            end
            c_st_resp: w_state_nxt = c_st_gap;
            c_st_gap: begin
                // A grant still held here means this gap precedes a retry.
                if (!m_en_tx && (r_gap == c_gap_lim))
                    w_state_nxt = (|r_gnt) ? c_st_launch : c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_done        = '0;
        w_rsp_err     = 1'b0;
        w_rsp_timeout = 1'b0;
        w_rsp_dat     = 8'h00;
        w_busy        = (w_state_nxt != c_st_idle);
        w_m_st        = (w_state_nxt == c_st_launch);
        if (w_state_nxt == c_st_resp) begin
            w_done = r_gnt;
            if (r_state == c_st_eval) begin
                w_rsp_err = r_err_cap;
                if (r_adr_com[c_r_w_bit] && !r_err_cap) w_rsp_dat = r_rx_cap;
            end else begin
                w_rsp_err     = 1'b1;
                w_rsp_timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done        <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_dat     <= 8'h00;
            r_busy        <= 1'b0;
            r_m_st        <= 1'b0;
        end else begin
            r_done        <= w_done;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
            r_rsp_dat     <= w_rsp_dat;
            r_busy        <= w_busy;
            r_m_st        <= w_m_st;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt     <= '0;
            r_adr_com <= 8'h00;
            r_adr_reg <= 8'h00;
            r_dat_reg <= 8'h00;
            r_retry   <= '0;
            r_wdog    <= '0;
            r_gap     <= '0;
            r_err_cap <= 1'b0;
            r_rx_cap  <= 8'h00;
        end else begin
            if (w_sel) begin
                r_gnt     <= w_pick;
                r_adr_com <= req_adr_com[{w_idx, 3'b000} +: 8];
                r_adr_reg <= req_adr_reg[{w_idx, 3'b000} +: 8];
                r_dat_reg <= req_dat_reg[{w_idx, 3'b000} +: 8];
                r_retry   <= '0;
            end else if (r_state == c_st_resp) begin
                r_gnt <= '0;
            end else if ((r_state == c_st_eval) && (w_state_nxt == c_st_gap)) begin
                r_retry <= r_retry + 1'b1;
            end

            // Watchdog counts cycles since st, restarting when en_tx is seen high.
            if ((w_state_nxt == c_st_launch) ||
                ((w_state_nxt == c_st_wait_done) && (r_state != c_st_wait_done)))
                r_wdog <= '0;
            else if ((r_state == c_st_launch) || (r_state == c_st_wait_busy) ||
                     (r_state == c_st_wait_done))
                r_wdog <= r_wdog + 1'b1;

            if ((r_state != c_st_gap) || m_en_tx) r_gap <= '0;
            else                                  r_gap <= r_gap + 1'b1;

            if ((r_state == c_st_wait_done) && !m_en_tx) begin
                r_err_cap <= m_err_ac;
                r_rx_cap  <= m_rx_dat;
            end
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign rsp_dat     = r_rsp_dat;
    assign busy        = r_busy;
    assign m_st        = r_m_st;
    assign m_adr_com   = r_adr_com;
    assign m_adr_reg   = r_adr_reg;
    assign m_dat_reg   = r_dat_reg;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_txn_sched
// Brief   : Directed self-checking bench for the I2C transaction scheduler.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_sched;

    localparam int N_REQ     = 2;
    localparam int MAX_RETRY = 2;
    localparam int GAP_CYC   = 40;
    localparam int START_TO  = 8;
    localparam int TIMEOUT   = 2048;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [15:0]      req_adr_com = '0, req_adr_reg = '0, req_dat_reg = '0;
    logic [N_REQ-1:0] gnt, done;
    logic             rsp_err, rsp_timeout, busy, m_st;
    logic [7:0]       rsp_dat, m_adr_com, m_adr_reg, m_dat_reg;
    logic             m_en_tx = 1'b0, m_err_ac = 1'b0;
    logic [7:0]       m_rx_dat = 8'h00;

    int total = 0;
    int bad   = 0;
    int st_cnt = 0;

    i2c_txn_sched #(
        .N_REQ(N_REQ), .MAX_RETRY(MAX_RETRY), .GAP_CYC(GAP_CYC),
        .START_TO(START_TO), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_adr_com(req_adr_com), .req_adr_reg(req_adr_reg), .req_dat_reg(req_dat_reg),
        .gnt(gnt), .done(done), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .rsp_dat(rsp_dat), .busy(busy), .m_st(m_st),
        .m_adr_com(m_adr_com), .m_adr_reg(m_adr_reg), .m_dat_reg(m_dat_reg),
        .m_en_tx(m_en_tx), .m_err_ac(m_err_ac), .m_rx_dat(m_rx_dat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (m_st) st_cnt <= st_cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input int limit, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < limit) begin
            tick();
            cyc++;
            if (m_st === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    // Simple master: en_tx rises the cycle after st, stays high len cycles.
    task automatic frame(input bit err, input logic [7:0] rx, input int len);
        tick();
        m_en_tx = 1'b1;
        repeat (len) tick();
        m_err_ac = err;
        m_rx_dat = rx;
        m_en_tx  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({gnt, done, rsp_err, rsp_timeout, rsp_dat, busy, m_st,
             m_adr_com, m_adr_reg, m_dat_reg} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {gnt, done, rsp_err, rsp_timeout,
                     rsp_dat, busy, m_st, m_adr_com, m_adr_reg, m_dat_reg});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        bit ok;
        bit moved;
        req_adr_com = 16'h00A0;
        req_adr_reg = 16'h0012;
        req_dat_reg = 16'h005A;
        req = 2'b01;
        tick();
        total++;
        if (m_st !== 1'b1 || gnt !== 2'b01 || busy !== 1'b1) begin
            bad++;
            $display("FAIL write_launch got st=%b gnt=%b busy=%b want 1 01 1", m_st, gnt, busy);
        end
        total++;
        if ({m_adr_com, m_adr_reg, m_dat_reg} !== 24'hA0125A) begin
            bad++;
            $display("FAIL write_operands got=%h want=a0125a", {m_adr_com, m_adr_reg, m_dat_reg});
        end
        req_adr_com = 16'h00FF;
        req_dat_reg = 16'h0000;
        tick();
        total++;
        if (m_st !== 1'b0) begin
            bad++;
            $display("FAIL write_st_width got=%b want=0", m_st);
        end
        m_en_tx = 1'b1;
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({m_adr_com, m_adr_reg, m_dat_reg} !== 24'hA0125A || m_st !== 1'b0) moved = 1'b1;
        end
        total++;
        if (moved) begin
            bad++;
            $display("FAIL write_stable got=changed want=held");
        end
        m_err_ac = 1'b0;
        m_rx_dat = 8'h77;
        m_en_tx  = 1'b0;
        tick();
        total++;
        if (done !== 2'b00) begin
            bad++;
            $display("FAIL write_done_early got=%b want=00", done);
        end
        tick();
        total++;
        if (done !== 2'b01 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_dat !== 8'h00 ||
            m_adr_com !== 8'hA0) begin
            bad++;
            $display("FAIL write_resp got done=%b err=%b to=%b dat=%h adr=%h want 01 0 0 00 a0",
                     done, rsp_err, rsp_timeout, rsp_dat, m_adr_com);
        end
        req = 2'b00;
        tick();
        total++;
        if (gnt !== 2'b00 || done !== 2'b00) begin
            bad++;
            $display("FAIL write_release got gnt=%b done=%b want 00 00", gnt, done);
        end
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL write_idle got=busy want=idle");
        end
    endtask

    task automatic test_read;
        bit ok;
        int cyc;
        req_adr_com = 16'hA100;
        req_adr_reg = 16'h3400;
        req = 2'b10;
        wait_st(5, cyc, ok);
        total++;
        if (!ok || cyc != 1 || gnt !== 2'b10 || m_adr_com !== 8'hA1 || m_adr_reg !== 8'h34) begin
            bad++;
            $display("FAIL read_launch got ok=%b cyc=%0d gnt=%b adr=%h reg=%h want 1 1 10 a1 34",
                     ok, cyc, gnt, m_adr_com, m_adr_reg);
        end
        frame(1'b0, 8'h3C, 20);
        tick();
        tick();
        total++;
        if (done !== 2'b10 || rsp_dat !== 8'h3C || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL read_resp got done=%b dat=%h err=%b want 10 3c 0", done, rsp_dat, rsp_err);
        end
        req = 2'b00;
        wait_idle(ok);
    endtask

    task automatic test_back_to_back;
        bit ok;
        int cyc;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_adr_com = 16'hA1A0;
        req = 2'b11;
        wait_st(5, cyc, ok);
        total++;
        if (!ok || gnt !== 2'b01) begin
            bad++;
            $display("FAIL rr_first got ok=%b gnt=%b want 1 01", ok, gnt);
        end
        frame(1'b0, 8'h55, 12);
        tick();
        tick();
        total++;
        if (done !== 2'b01 || rsp_dat !== 8'h00) begin
            bad++;
            $display("FAIL rr_first_resp got done=%b dat=%h want 01 00", done, rsp_dat);
        end
        wait_st(100, cyc, ok);
        total++;
        if (!ok || gnt !== 2'b10 || m_adr_com !== 8'hA1 || cyc + 2 < GAP_CYC) begin
            bad++;
            $display("FAIL rr_second got ok=%b gnt=%b adr=%h gap=%0d want 1 10 a1 >=%0d",
                     ok, gnt, m_adr_com, cyc + 2, GAP_CYC);
        end
        frame(1'b0, 8'hC3, 12);
        tick();
        tick();
        total++;
        if (done !== 2'b10 || rsp_dat !== 8'hC3) begin
            bad++;
            $display("FAIL rr_second_resp got done=%b dat=%h want 10 c3", done, rsp_dat);
        end
        req = 2'b00;
        wait_idle(ok);
        req = 2'b11;
        wait_st(5, cyc, ok);
        total++;
        if (!ok || gnt !== 2'b01) begin
            bad++;
            $display("FAIL rr_wrap got ok=%b gnt=%b want 1 01", ok, gnt);
        end
        frame(1'b0, 8'h00, 12);
        tick();
        tick();
        req = 2'b00;
        wait_idle(ok);
    endtask

    task automatic test_nack_retry;
        bit ok;
        int cyc;
        int base;
        base = st_cnt;
        req_adr_com = 16'h00A1;
        req = 2'b01;
        for (int a = 0; a < 3; a++) begin
            wait_st((a == 0) ? 5 : 100, cyc, ok);
            total++;
            if (!ok || (a > 0 && cyc < GAP_CYC)) begin
                bad++;
                $display("FAIL nack_st%0d got ok=%b gap=%0d want 1 >=%0d", a, ok, cyc, GAP_CYC);
            end
            frame(1'b1, 8'hEE, 15);
        end
        tick();
        tick();
        total++;
        if (done !== 2'b01 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_dat !== 8'h00) begin
            bad++;
            $display("FAIL nack_resp got done=%b err=%b to=%b dat=%h want 01 1 0 00",
                     done, rsp_err, rsp_timeout, rsp_dat);
        end
        req = 2'b00;
        wait_idle(ok);
        total++;
        if (st_cnt - base != 3) begin
            bad++;
            $display("FAIL nack_st_count got=%0d want=3", st_cnt - base);
        end
    endtask

    task automatic test_start_timeout;
        bit ok;
        int cyc;
        req_adr_com = 16'h00A1;
        req = 2'b01;
        wait_st(5, cyc, ok);
        repeat (START_TO - 1) tick();
        total++;
        if (!ok || done !== 2'b00) begin
            bad++;
            $display("FAIL sto_early got ok=%b done=%b want 1 00", ok, done);
        end
        tick();
        total++;
        if (done !== 2'b01 || rsp_timeout !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 8'h00) begin
            bad++;
            $display("FAIL sto_resp got done=%b to=%b err=%b dat=%h want 01 1 1 00",
                     done, rsp_timeout, rsp_err, rsp_dat);
        end
        req = 2'b00;
        wait_idle(ok);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int cyc;
        int base;
        req_adr_com = 16'h00A0;
        req = 2'b01;
        wait_st(5, cyc, ok);
        tick();
        m_en_tx = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (gnt !== 2'b00 || busy !== 1'b0 || m_st !== 1'b0) begin
            bad++;
            $display("FAIL rmid_reset got gnt=%b busy=%b st=%b want 00 0 0", gnt, busy, m_st);
        end
        base = st_cnt;
        repeat (10) tick();
        total++;
        if (st_cnt != base || busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_hold got st=%0d busy=%b want 0 0", st_cnt - base, busy);
        end
        m_en_tx = 1'b0;
        wait_st(5, cyc, ok);
        total++;
        if (!ok || gnt !== 2'b01) begin
            bad++;
            $display("FAIL rmid_regrant got ok=%b gnt=%b want 1 01", ok, gnt);
        end
        frame(1'b0, 8'h00, 10);
        tick();
        tick();
        total++;
        if (done !== 2'b01 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL rmid_resp got done=%b err=%b want 01 0", done, rsp_err);
        end
        req = 2'b00;
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_nack_retry();
        test_start_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=stuck want=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
`default_nettype wire
